// File: rtl/desconcatena_pkg.sv
// Shared constants for the response deserializer: state encoding, default
// sizes and the bit-index width helper.
package desconcatena_pkg;

   localparam int ANCHO_DEF = 4;
   localparam int PROF_DEF  = 2;
   localparam int IDX_W_DEF = $clog2(ANCHO_DEF + 1);

   localparam logic [0:0] REPOSO   = 1'b0;
   localparam logic [0:0] DESPLAZA = 1'b1;

   function automatic int anchoIndice(input int ancho);
      return $clog2(ancho + 1);
   endfunction

endpackage

// File: rtl/desconcatena_serie_fila_tuplas.sv
// fila_tuplas: small synchronous FIFO holding whole response words until the
// serializer is free to take them.
module fila_tuplas
   import desconcatena_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF,
   parameter int PROF  = PROF_DEF
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic [ANCHO-1:0]              dato_i,
   output logic [ANCHO-1:0]              dato_o,
   output logic                          vacia_o,
   output logic                          llena_o,
   output logic [$clog2(PROF+1)-1:0]     cuenta_o
);

   localparam int PTR_W = (PROF > 1) ? $clog2(PROF) : 1;
   localparam int CNT_W = $clog2(PROF + 1);

   logic [ANCHO-1:0] mem_q [PROF];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pushOk, popOk;

   function automatic logic [PTR_W-1:0] siguiente(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(PROF - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign vacia_o  = (cnt_q == '0);
   assign llena_o  = (cnt_q == CNT_W'(PROF));
   assign cuenta_o = cnt_q;
   assign dato_o   = mem_q[rd_q];
   assign pushOk   = push_i & ~llena_o;
   assign popOk    = pop_i & ~vacia_o;

   always_comb begin
      wr_d  = pushOk ? siguiente(wr_q) : wr_q;
      rd_d  = popOk ? siguiente(rd_q) : rd_q;
      cnt_d = cnt_q + CNT_W'(pushOk) - CNT_W'(popOk);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is not reset; the empty count guards against reading stale words.
   always_ff @(posedge clk_i) begin
      if (pushOk) begin
         mem_q[wr_q] <= dato_i;
      end
   end

endmodule

// File: rtl/desconcatena_serie.sv
// Deconcatenates {Cy_Rta, Respuesta} into an LSB-first bit stream with a
// last-bit marker. Define PARIDAD_EN to append an even-parity bit per word.
module desconcatena_serie
   import desconcatena_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF,
   parameter int PROF  = PROF_DEF
) (
   input  logic             Reloj,
   input  logic             Reinicio,
   input  logic [ANCHO-2:0] Respuesta,
   input  logic             Cy_Rta,
   input  logic             Entrada_Valida,
   output logic             Entrada_Lista,
   input  logic             Salida_Lista,
   output logic             Bit_Salida,
   output logic             Bit_Valido,
   output logic             Ultimo_Bit,
   output logic             Ocupado
);

   localparam int IDX_W = anchoIndice(ANCHO);
`ifdef PARIDAD_EN
   localparam int SH_W = ANCHO + 1;
`else
   localparam int SH_W = ANCHO;
`endif
   localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(SH_W - 1);

   logic [0:0]              estado_q, estado_d;
   logic [SH_W-1:0]         shift_q, shift_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SH_W-1:0]         carga;
   logic [ANCHO-1:0]        filaDato;
   logic [$clog2(PROF+1)-1:0] filaCuenta;
   logic                    filaVacia, filaLlena;
   logic                    push, pop;

   assign Entrada_Lista = ~Reinicio & ~filaLlena;
   assign push          = Entrada_Valida & Entrada_Lista;

   fila_tuplas #(
      .ANCHO (ANCHO),
      .PROF  (PROF)
   ) uFila (
      .clk_i    (Reloj),
      .reset_i  (Reinicio),
      .push_i   (push),
      .pop_i    (pop),
      .dato_i   ({Cy_Rta, Respuesta}),
      .dato_o   (filaDato),
      .vacia_o  (filaVacia),
      .llena_o  (filaLlena),
      .cuenta_o (filaCuenta)
   );

`ifdef PARIDAD_EN
   assign carga = {^filaDato, filaDato};
`else
   assign carga = filaDato;
`endif

   // On the last transfer the next queued word is loaded in the same edge.
   always_comb begin
      estado_d = estado_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      pop      = 1'b0;
      if (estado_q == REPOSO) begin
         if (!filaVacia) begin
            pop      = 1'b1;
            shift_d  = carga;
            idx_d    = '0;
            estado_d = DESPLAZA;
         end
      end else if (Salida_Lista) begin
         if (idx_q == ULTIMO) begin
            if (!filaVacia) begin
               pop     = 1'b1;
               shift_d = carga;
               idx_d   = '0;
            end else begin
               shift_d  = shift_q >> 1;
               estado_d = REPOSO;
            end
         end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge Reloj) begin
      if (Reinicio) begin
         estado_q <= REPOSO;
         shift_q  <= '0;
         idx_q    <= '0;
      end else begin
         estado_q <= estado_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
      end
   end

   assign Bit_Valido = (estado_q == DESPLAZA);
   assign Bit_Salida = Bit_Valido & shift_q[0];
   assign Ultimo_Bit = Bit_Valido & (idx_q == ULTIMO);
   assign Ocupado    = (filaCuenta != '0) | Bit_Valido;

endmodule

// File: tb/tb_desconcatena_serie.sv
// Scoreboard bench for desconcatena_serie: accepted words expand into expected
// {bit, last} entries that are compared as the serial stream is consumed.
module tb_desconcatena_serie;

   localparam int ANCHO = 4;
   localparam int PROF  = 2;

   logic             Reloj = 1'b0;
   logic             Reinicio;
   logic [ANCHO-2:0] Respuesta;
   logic             Cy_Rta;
   logic             Entrada_Valida;
   logic             Entrada_Lista;
   logic             Salida_Lista;
   logic             Bit_Salida;
   logic             Bit_Valido;
   logic             Ultimo_Bit;
   logic             Ocupado;

   logic [1:0] expQ [$];
   int nChecks = 0;
   int nFails  = 0;
   int nXfer   = 0;

   desconcatena_serie #(
      .ANCHO (ANCHO),
      .PROF  (PROF)
   ) dut (
      .Reloj          (Reloj),
      .Reinicio       (Reinicio),
      .Respuesta      (Respuesta),
      .Cy_Rta         (Cy_Rta),
      .Entrada_Valida (Entrada_Valida),
      .Entrada_Lista  (Entrada_Lista),
      .Salida_Lista   (Salida_Lista),
      .Bit_Salida     (Bit_Salida),
      .Bit_Valido     (Bit_Valido),
      .Ultimo_Bit     (Ultimo_Bit),
      .Ocupado        (Ocupado)
   );

   always #5 Reloj = ~Reloj;

   // Safety net in case a DUT fault stalls something unexpectedly.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got still running, expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected stream for one word: LSB first, marker on the final transfer.
   task automatic pushWord(input logic [ANCHO-1:0] w);
      for (int i = 0; i < ANCHO; i++) begin
`ifdef PARIDAD_EN
         expQ.push_back({w[i], 1'b0});
`else
         expQ.push_back({w[i], (i == ANCHO - 1) ? 1'b1 : 1'b0});
`endif
      end
`ifdef PARIDAD_EN
      expQ.push_back({^w, 1'b1});
`endif
   endtask

   // One clock: monitor on the falling edge, then advance past the rising edge.
   task automatic tick();
      logic [1:0] e;
      @(negedge Reloj);
      if (Reinicio) begin
         expQ.delete();
      end else begin
         if (Bit_Valido) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_bit", 32'(Bit_Valido), 32'd0);
            end else begin
               e = expQ[0];
               checkOutput("bit", 32'(Bit_Salida), 32'(e[1]));
               checkOutput("ultimo", 32'(Ultimo_Bit), 32'(e[0]));
               if (Salida_Lista) begin
                  void'(expQ.pop_front());
                  nXfer++;
               end
            end
         end
         if (Entrada_Valida && Entrada_Lista) begin
            pushWord({Cy_Rta, Respuesta});
         end
      end
      @(posedge Reloj);
      #1;
   endtask

   // Present a word and hold it until the block accepts it.
   task automatic applyStimulus(input logic [ANCHO-1:0] w);
      logic acc;
      int   n;
      Respuesta      = w[ANCHO-2:0];
      Cy_Rta         = w[ANCHO-1];
      Entrada_Valida = 1'b1;
      n = 0;
      do begin
         acc = Entrada_Lista;
         tick();
         n++;
      end while (!acc && n < 50);
      checkOutput("accept", 32'(acc), 32'd1);
      Entrada_Valida = 1'b0;
   endtask

   task automatic drain(input string tag, input bit checkGap);
      int n  = 0;
      int s0 = expQ.size();
      while (expQ.size() > 0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput({tag, "_empty"}, 32'(expQ.size()), 32'd0);
      if (checkGap) checkOutput({tag, "_nogap"}, 32'(n), 32'(s0));
      checkOutput({tag, "_idle"}, 32'(Ocupado), 32'd0);
   endtask

   initial begin
      int n;
      int x0;
      Reinicio       = 1'b1;
      Respuesta      = '0;
      Cy_Rta         = 1'b0;
      Entrada_Valida = 1'b0;
      Salida_Lista   = 1'b0;

      // Reset held two cycles, outputs all low
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst_lista", 32'(Entrada_Lista), 32'd0);
         checkOutput("rst_valido", 32'(Bit_Valido), 32'd0);
         checkOutput("rst_bit", 32'(Bit_Salida), 32'd0);
         checkOutput("rst_ultimo", 32'(Ultimo_Bit), 32'd0);
         checkOutput("rst_ocupado", 32'(Ocupado), 32'd0);
      end
      Reinicio = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("idle_lista", 32'(Entrada_Lista), 32'd1);
         checkOutput("idle_ocupado", 32'(Ocupado), 32'd0);
         checkOutput("idle_valido", 32'(Bit_Valido), 32'd0);
      end

      // Single word 1101 with two-cycle latency
      Salida_Lista = 1'b1;
      applyStimulus(4'b1101);
      checkOutput("lat_not_yet", 32'(Bit_Valido), 32'd0);
      checkOutput("lat_ocupado", 32'(Ocupado), 32'd1);
      tick();
      checkOutput("lat_first", 32'(Bit_Valido), 32'd1);
      drain("single", 1'b1);

      // Back-to-back words, no idle cycle between them
      applyStimulus(4'b0100);
      applyStimulus(4'b1011);
      checkOutput("b2b_start", 32'(Bit_Valido), 32'd1);
      drain("b2b", 1'b1);

      // Backpressure fills the queue; the fourth word must wait
      Salida_Lista = 1'b0;
      applyStimulus(4'h6);
      applyStimulus(4'h9);
      applyStimulus(4'hC);
      checkOutput("full_lista", 32'(Entrada_Lista), 32'd0);
      checkOutput("full_ocupado", 32'(Ocupado), 32'd1);
      Respuesta      = 3'b011;
      Cy_Rta         = 1'b0;
      Entrada_Valida = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("full_hold", 32'(Entrada_Lista), 32'd0);
      end
      Salida_Lista = 1'b1;
      applyStimulus(4'h3);
      drain("bp", 1'b0);

      // Reset in the middle of a word discards it
      applyStimulus(4'b1110);
      x0 = nXfer;
      n  = 0;
      while (nXfer - x0 < 2 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("mid_two_bits", 32'(nXfer - x0), 32'd2);
      Reinicio = 1'b1;
      tick();
      checkOutput("mid_valido", 32'(Bit_Valido), 32'd0);
      checkOutput("mid_ocupado", 32'(Ocupado), 32'd0);
      checkOutput("mid_lista", 32'(Entrada_Lista), 32'd0);
      Reinicio = 1'b0;
      tick();
      checkOutput("mid_after_valido", 32'(Bit_Valido), 32'd0);
      checkOutput("mid_after_lista", 32'(Entrada_Lista), 32'd1);
      applyStimulus(4'b0001);
      tick();
      drain("mid_new", 1'b1);

      // Push lands on the same edge as the last bit of the current word
      applyStimulus(4'hA);
      tick();
      applyStimulus(4'h5);
      n = 0;
      while (!Ultimo_Bit && n < 50) begin
         tick();
         n++;
      end
      checkOutput("pp_at_last", 32'(Ultimo_Bit), 32'd1);
      applyStimulus(4'h7);
      checkOutput("pp_count1", 32'(Entrada_Lista), 32'd1);
      checkOutput("pp_valido", 32'(Bit_Valido), 32'd1);
      checkOutput("pp_first_not_last", 32'(Ultimo_Bit), 32'd0);
      drain("pp", 1'b1);

      // Random traffic with random backpressure
      for (int i = 0; i < 200; i++) begin
         Entrada_Valida = 1'($urandom_range(0, 1));
         Respuesta      = (ANCHO-1)'($urandom);
         Cy_Rta         = 1'($urandom);
         Salida_Lista   = ($urandom_range(0, 3) != 0);
         tick();
      end
      Entrada_Valida = 1'b0;
      Salida_Lista   = 1'b1;
      drain("rand", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
